// File: rtl/uart_rx_fifo_if.sv
// Receive-side bundle between the UART receiver/FIFO and its consumer.
// master drives the serial line and pops; slave is the receiver itself.
interface uart_rx_fifo_if #(parameter int FIFO_AW = 3);
  logic               rx_in;
  logic               rd_en;
  logic [7:0]         dout;
  logic               empty;
  logic               full;
  logic [FIFO_AW:0]   count;
  logic               frame_err;
  logic               overrun;
  logic               parity_err;

  modport master (
    output rx_in, rd_en,
    input  dout, empty, full, count, frame_err, overrun, parity_err
  );

  modport slave (
    input  rx_in, rd_en,
    output dout, empty, full, count, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8-bit UART receiver (mid-bit sampling) feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN for an 11-bit frame with even parity and parity_err reporting.
//
// state  | meaning
// IDLE   | line idle, waiting for rxs to fall
// START  | half bit wait, confirm start bit still low
// DATA   | sample 8 data bits LSB first
// PARITY | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sample stop bit, push or report
// BREAK  | stop bit was low, wait for line to return high
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 3
) (
  input  logic           clk,
  input  logic           rstn,
  uart_rx_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic          rx_s1, rxs;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bad;

  logic          tick;
  logic          stop_sample;
  logic          push_req;
  logic          fe_req;
  logic          pe_req;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= bus.rx_in;
      rxs   <= rx_s1;
    end
  end

  assign tick        = (timer == '0);
  assign stop_sample = (state == STOP) && tick;
  assign push_req    = stop_sample && rxs && !par_bad;
  assign fe_req      = stop_sample && !rxs;
  assign pe_req      = stop_sample && rxs && par_bad;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          par_bad <= 1'b0;
          if (!rxs) begin
            state <= START;
            timer <= T_HALF;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              timer <= T_FULL;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            timer   <= T_FULL;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_bad <= ^{shreg, rxs};
            state   <= STOP;
            timer   <= T_FULL;
          end else begin
            timer <= timer - 1'b1;
          end
        end
`endif
        // Leave mid stop bit so the next start edge is never missed.
        STOP: begin
          if (tick) begin
            state <= rxs ? IDLE : BREAK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr, rptr_nxt;
  logic [FIFO_AW:0]   cnt, cnt_nxt;
  logic               is_full, do_pop, do_push;
  logic [7:0]         head_nxt;

  assign is_full = (cnt == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = bus.rd_en && (cnt != '0);
  assign do_push = push_req && (!is_full || do_pop);

  // The slot being written this cycle becomes head only when the FIFO drains to it.
  always_comb begin
    rptr_nxt = do_pop ? rptr + 1'b1 : rptr;
    cnt_nxt  = cnt + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, do_pop};
    head_nxt = (do_push && (rptr_nxt == wptr)) ? shreg : mem[rptr_nxt];
    if (cnt_nxt == '0) head_nxt = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr           <= '0;
      rptr           <= '0;
      cnt            <= '0;
      bus.dout       <= 8'h00;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      rptr           <= rptr_nxt;
      cnt            <= cnt_nxt;
      bus.dout       <= head_nxt;
      bus.frame_err  <= fe_req;
      bus.overrun    <= push_req && is_full && !do_pop;
`ifdef UART_RX_PARITY_EN
      bus.parity_err <= pe_req;
`else
      bus.parity_err <= 1'b0;
`endif
    end
  end

  assign bus.count = cnt;
  assign bus.empty = (cnt == '0);
  assign bus.full  = is_full;

`ifndef UART_RX_PARITY_EN
  logic unused_pe;
  assign unused_pe = pe_req;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued when frames are sent,
// popped and compared as the FIFO is read.
module tb_uart_rx_fifo;

  localparam int CPB     = 64;
  localparam int FIFO_AW = 3;

  logic clk;
  logic rstn;

  uart_rx_fifo_if #(.FIFO_AW(FIFO_AW)) u_if ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(FIFO_AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (u_if.frame_err  === 1'b1) fe_cnt++;
      if (u_if.overrun    === 1'b1) ov_cnt++;
      if (u_if.parity_err === 1'b1) pe_cnt++;
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    u_if.rx_in = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_good, input logic expect_push);
    if (expect_push) exp_q.push_back(d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ ~par_good);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic read_expect(input string name);
    logic [7:0] exp;
    int waited = 0;
    while (u_if.empty !== 1'b0 && waited < 20 * CPB) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: got dout=%h with nothing expected", name, u_if.dout);
      return;
    end
    exp = exp_q.pop_front();
    if (u_if.empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: timeout waiting for byte, required %h", name, exp);
      return;
    end
    if (u_if.dout !== exp) begin
      tests_failed++;
      $display("FAIL %s: dout=%h required %h", name, u_if.dout, exp);
    end
    u_if.rd_en = 1'b1;
    @(negedge clk);
    u_if.rd_en = 1'b0;
  endtask

  task automatic test_reset;
    int bad = 0;
    rstn = 1'b0;
    u_if.rx_in = 1'b1;
    u_if.rd_en = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (u_if.empty !== 1'b1 || u_if.count !== '0 || u_if.dout !== 8'h00 ||
          u_if.full !== 1'b0 || u_if.frame_err !== 1'b0 ||
          u_if.overrun !== 1'b0 || u_if.parity_err !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
    end
    tests_run++;
    if (u_if.empty !== 1'b1 || u_if.count !== 4'd0 || u_if.dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_values: empty=%b count=%0d dout=%h required 1/0/00",
               u_if.empty, u_if.count, u_if.dout);
    end
  endtask

  task automatic test_single;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (u_if.empty !== 1'b0 || u_if.count !== 4'd1 || u_if.dout !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_status: empty=%b count=%0d dout=%h required 0/1/a5",
               u_if.empty, u_if.count, u_if.dout);
    end
    read_expect("single_read");
    tests_run++;
    if (u_if.empty !== 1'b1 || u_if.dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_pop: empty=%b dout=%h required 1/00", u_if.empty, u_if.dout);
    end
  endtask

  task automatic test_back_to_back;
    int ov0 = ov_cnt;
    for (int i = 0; i < 9; i++)
      send_frame(8'(i), 1'b1, 1'b1, (i < 8));
    tests_run++;
    if (u_if.count !== 4'd8 || u_if.full !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_full: count=%0d full=%b required 8/1", u_if.count, u_if.full);
    end
    tests_run++;
    if (ov_cnt - ov0 !== 1) begin
      tests_failed++;
      $display("FAIL b2b_overrun: pulses=%0d required 1", ov_cnt - ov0);
    end
    for (int i = 0; i < 8; i++) read_expect("b2b_read");
    tests_run++;
    if (u_if.empty !== 1'b1 || u_if.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL b2b_drain: empty=%b count=%0d required 1/0", u_if.empty, u_if.count);
    end
  endtask

  task automatic test_glitch;
    int fe0 = fe_cnt;
    @(negedge clk);
    u_if.rx_in = 1'b0;
    repeat (15) @(negedge clk);
    u_if.rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    tests_run++;
    if (u_if.count !== 4'd0 || fe_cnt - fe0 !== 0) begin
      tests_failed++;
      $display("FAIL glitch_reject: count=%0d frame_err=%0d required 0/0",
               u_if.count, fe_cnt - fe0);
    end
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    read_expect("glitch_then_3c");
  endtask

  task automatic test_frame_err;
    int fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    u_if.rx_in = 1'b1;
    repeat (CPB) @(negedge clk);
    tests_run++;
    if (fe_cnt - fe0 !== 1 || u_if.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL frame_err: pulses=%0d count=%0d required 1/0", fe_cnt - fe0, u_if.count);
    end
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    read_expect("after_break_c3");
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int pe0 = pe_cnt;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
    read_expect("parity_good_0f");
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    repeat (CPB) @(negedge clk);
    tests_run++;
    if (pe_cnt - pe0 !== 1 || u_if.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL parity_err: pulses=%0d count=%0d required 1/0", pe_cnt - pe0, u_if.count);
    end
`else
    tests_run++;
    if (pe_cnt !== 0) begin
      tests_failed++;
      $display("FAIL parity_tied: pulses=%0d required 0", pe_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    @(negedge clk);
    rstn = 1'b0;
    u_if.rx_in = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (u_if.empty !== 1'b1 || u_if.count !== 4'd0 || u_if.dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset: empty=%b count=%0d dout=%h required 1/0/00",
               u_if.empty, u_if.count, u_if.dout);
    end
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    read_expect("after_reset_81");
    tests_run++;
    if (u_if.empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_reset_empty: empty=%b required 1", u_if.empty);
    end
  endtask

  initial begin
    u_if.rx_in = 1'b1;
    u_if.rd_en = 1'b0;
    rstn = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_parity();
    test_mid_reset();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_left: %0d bytes never received, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
